// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and sizing for the FIFO-to-stream reader and its skid buffer.
package fifo_rd_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int SKID_DEPTH = 3;

  typedef logic [1:0] ptr_t;
  typedef logic [1:0] occ_t;

  // Circular pointer advance over the three buffer slots (2 wraps to 0).
  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(SKID_DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + ptr_t'(1));
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read-side and valid/ready stream signals; master is the reader block.
interface fifo_stream_reader_if #(
  parameter int DW = 8
);

  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Three-entry circular queue that absorbs FIFO read latency ahead of the stream.
module skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output occ_t          occ
);

  logic [DW-1:0] mem [SKID_DEPTH];
  ptr_t          head;
  ptr_t          tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   occ <= occ + occ_t'(1);
        2'b01:   occ <= occ - occ_t'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a registered-output FIFO into a valid/ready stream via a 3-entry skid buffer.
// Optional transfer counter rd_count is enabled by defining FIFO_RD_CNT_EN.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  fifo_stream_reader_if.master bus
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0] rd_count
`endif
);

  logic    inflight;
  occ_t    occ;
  logic    pop;
  logic [2:0] level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= bus.fifo_rd_en;
  end

  // Request only while the buffer plus the byte already in flight leaves a free slot,
  // so the request never depends on m_ready.
  assign level          = {1'b0, occ} + {2'b00, inflight};
  assign bus.fifo_rd_en = rst_n && !bus.fifo_empty && (level <= 3'd2);

  assign bus.m_valid = (occ != occ_t'(0));
  assign pop         = bus.m_valid && bus.m_ready;

  skid_buf #(.DW(DW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (bus.fifo_dout),
    .pop       (pop),
    .head_data (bus.m_data),
    .occ       (occ)
  );

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rd_count <= '0;
    else if (pop) rd_count <= rd_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: bytes pushed into a FIFO model are
// expected on the stream in order; covers latency, backpressure, random traffic and reset.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst_n;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_count;
`endif

  fifo_stream_reader_if #(.DW(8)) bus ();

  fifo_stream_reader #(.DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count (rd_count)
`endif
  );

  always #5 clk = ~clk;

  // Registered-read FIFO model: storage is never popped, only the read index moves.
  logic [7:0] fifo_mem [$];
  int         rd_ptr = 0;
  assign bus.fifo_empty = (rd_ptr >= fifo_mem.size());

  always @(posedge clk) begin
    if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int xfers = 0;
  int xfers_since_rst = 0;
  int dropped = 0;
  logic [7:0] next_val;
  logic obs_valid, obs_rd_en, obs_ready, obs_empty;
  logic [7:0] obs_data;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Push n bytes into the FIFO and the scoreboard (sequential values or random).
  task automatic applyStimulus(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic [7:0] v;
      v = rnd ? 8'($urandom) : next_val;
      next_val = next_val + 8'd1;
      fifo_mem.push_back(v);
      exp_q.push_back(v);
    end
  endtask

  // Observe one cycle at the falling edge, score any transfer, return just after the rising edge.
  task automatic stepCycle();
    @(negedge clk);
    obs_valid = bus.m_valid;
    obs_data  = bus.m_data;
    obs_rd_en = bus.fifo_rd_en;
    obs_ready = bus.m_ready;
    obs_empty = bus.fifo_empty;
    if (obs_empty) checkOutput("overread", {31'd0, obs_rd_en}, 32'd0);
    if (rst_n && obs_valid && obs_ready) begin
      if (exp_q.size() == 0) checkOutput("sb_extra", 32'd1, 32'd0);
      else checkOutput("sb_data", {24'd0, obs_data}, {24'd0, exp_q.pop_front()});
      xfers++;
      xfers_since_rst++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    for (int c = 0; c < bound && exp_q.size() > 0; c++) stepCycle();
  endtask

  initial begin
    #20_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_rd, first_v, run, pulses, x0, pushed, n, drop;
    bit ended;

    rst_n = 1'b0;
    bus.m_ready = 1'b0;
    next_val = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, bus.m_valid}, 32'd0);
    checkOutput("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    rst_n = 1'b1;

    // Empty FIFO: nothing requested, nothing presented
    for (int c = 0; c < 20; c++) begin
      stepCycle();
      checkOutput("idle_valid", {31'd0, obs_valid}, 32'd0);
      checkOutput("idle_rd_en", {31'd0, obs_rd_en}, 32'd0);
    end

    // 16 bytes, sink always ready: 2-cycle latency then one byte per cycle
    bus.m_ready = 1'b1;
    next_val = 8'h00;
    applyStimulus(16, 1'b0);
    first_rd = -1; first_v = -1; run = 0; ended = 1'b0;
    for (int c = 0; c < 40; c++) begin
      stepCycle();
      if (obs_rd_en && first_rd < 0) first_rd = c;
      if (obs_valid) begin
        if (first_v < 0) first_v = c;
        if (!ended) run++;
      end else if (first_v >= 0) ended = 1'b1;
    end
    checkOutput("first_rd_cycle", first_rd, 0);
    checkOutput("latency", first_v - first_rd, 2);
    checkOutput("burst_len", run, 16);
    checkOutput("burst_done_valid", {31'd0, obs_valid}, 32'd0);
    checkOutput("burst_sb_empty", exp_q.size(), 0);

    // Backpressure: exactly three reads fill the buffer, head holds 0x00
    bus.m_ready = 1'b0;
    next_val = 8'h00;
    applyStimulus(16, 1'b0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      stepCycle();
      pulses += int'(obs_rd_en);
      if (c >= 6) begin
        checkOutput("stall_valid", {31'd0, obs_valid}, 32'd1);
        checkOutput("stall_data", {24'd0, obs_data}, 32'h00);
      end
    end
    checkOutput("stall_pulses", pulses, 3);
    checkOutput("stall_occ", {30'd0, dut.u_buf.occ}, 32'd3);
    bus.m_ready = 1'b1;
    x0 = xfers;
    drain(100);
    checkOutput("stall_drain_cnt", xfers - x0, 16);
    checkOutput("stall_sb_empty", exp_q.size(), 0);

    // Random fills and random sink readiness, 1000 bytes
    pushed = 0;
    x0 = xfers;
    for (int c = 0; c < 20000 && (pushed < 1000 || exp_q.size() > 0); c++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 3) == 0) begin
        n = int'($urandom_range(1, 8));
        if (n > 1000 - pushed) n = 1000 - pushed;
        applyStimulus(n, 1'b1);
        pushed += n;
      end
      stepCycle();
    end
    checkOutput("rand_cnt", xfers - x0, 1000);
    checkOutput("rand_sb_empty", exp_q.size(), 0);

    // Reset with two buffered bytes and one in flight: all three are discarded
    bus.m_ready = 1'b0;
    next_val = 8'h40;
    applyStimulus(5, 1'b0);
    repeat (3) stepCycle();
    checkOutput("pre_rst_occ", {30'd0, dut.u_buf.occ}, 32'd2);
    checkOutput("pre_rst_inflight", {31'd0, dut.inflight}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'd0, bus.m_valid}, 32'd0);
    checkOutput("mid_rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    drop = rd_ptr - xfers - dropped;
    checkOutput("rst_drop_cnt", drop, 3);
    for (int i = 0; i < drop; i++) void'(exp_q.pop_front());
    dropped += drop;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    xfers_since_rst = 0;
    bus.m_ready = 1'b1;
    stepCycle();
    checkOutput("rd_after_rst", {31'd0, obs_rd_en}, 32'd1);
    x0 = xfers;
    drain(50);
    checkOutput("post_rst_cnt", xfers - x0, 2);
    checkOutput("post_rst_sb_empty", exp_q.size(), 0);

`ifdef FIFO_RD_CNT_EN
    checkOutput("rd_count_small", {16'd0, rd_count}, xfers_since_rst & 32'hFFFF);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    xfers_since_rst = 0;
    checkOutput("rd_count_rst", {16'd0, rd_count}, 32'd0);
    applyStimulus(65537, 1'b1);
    drain(70000);
    repeat (3) stepCycle();
    checkOutput("wrap_sb_empty", exp_q.size(), 0);
    checkOutput("rd_count_wrap", {16'd0, rd_count}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
